mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
EX-stage multiply/divide responder. Consumes the start/MDCCtrl/MDM_WE/MDM_RE control fields that the ID/EX pipeline register launches, and owns the architectural HI/LO registers. It runs mult/multu/div/divu over a fixed multi-cycle latency and raises busy so the hazard unit stalls later HI/LO users. It also serves mthi/mtlo writes and mfhi/mflo reads.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range >=1).
DIV_CYCLES, 10, busy cycles for div/divu (legal range >=1).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset; asserted when 0.
start  input  1  one-cycle launch pulse for the operation in MDCCtrl.
MDCCtrl  input  3  0=mult, 1=multu, 2=div, 3=divu; 4..7 reserved (start ignored).
A  input  32  rs operand (forwarded value).
B  input  32  rt operand (forwarded value).
MDM_WE  input  2  01=mthi (HI<=A), 10=mtlo (LO<=A), 00/11=no write.
MDM_RE  input  2  01=read HI, 10=read LO, else read 0.
busy  output  1  operation in flight.
HI  output  32  HI register.
LO  output  32  LO register.
MD_out  output  32  combinational read data selected by MDM_RE.

Behaviour:
- reset=0 (any time, including mid-operation): busy=0, HI=0, LO=0, counter=0, latched operands/op cleared immediately without waiting for clk. MD_out then follows MDM_RE over the cleared HI/LO.
- States: IDLE (busy=0) and RUN (busy=1), with a down-counter cnt.
- IDLE, start=1 with valid MDCCtrl at edge T:
  - latch A, B and op;
  - cnt<=N (N = MULT_CYCLES or DIV_CYCLES);
  - busy=1 from cycle T+1.
- RUN, each edge: if cnt>1, cnt<=cnt-1. If cnt==1, write the result to HI/LO, set busy<=0 and go to IDLE.
- Result: busy is high for exactly N cycles; HI/LO show the result in the first cycle after busy falls.
- Arithmetic uses latched operands only; A/B changes during RUN have no effect.
  - mult: signed 64-bit product; HI=[63:32], LO=[31:0].
  - multu: unsigned 64-bit product; HI=[63:32], LO=[31:0].
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (div or divu): run the full DIV_CYCLES with busy, then leave HI/LO unchanged.
- MDM_WE is honoured only in IDLE with start=0; the write takes effect at that edge.
  - Ignored in RUN (the hazard unit already stalls).
  - If start and MDM_WE are both asserted, start wins and the write is dropped.
- start in RUN is ignored; no restart, no queueing.
- Reserved MDCCtrl with start=1: no state change; busy stays 0.
- MD_out is purely combinational on current HI/LO. A read in the same cycle as an mthi write returns the old value.
- No registered output depends on MDM_RE.
- Stall contract (informative): the hazard unit stalls any ID-stage HI/LO instruction while start_EX|busy.

Test Plan:
- Reset, then mult A=0xFFFFFFFF B=0x00000002 (start at edge T) -> busy=1 for cycles T+1..T+5; at T+6 busy=0, HI=0xFFFFFFFF, LO=0xFFFFFFFE; MDM_RE=10 gives MD_out=0xFFFFFFFE.
- multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles. div A=0xFFFFFFF9 (-7) B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1.
- Corner divisions:
  - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - divu by B=0 with preloaded HI=0x11, LO=0x22 -> busy for 10 cycles, then HI=0x11, LO=0x22 unchanged.
- mtlo A=0x1234 while busy -> LO unchanged at completion (equals the result).
- A second start mid-RUN -> ignored: busy still falls after the original N cycles, and the result is that of the first operands.
- start and MDM_WE=01 in the same IDLE cycle -> HI not written by mthi.
- mult started, then reset=0 pulsed asynchronously between clock edges at cycle T+3 -> busy, HI and LO go to 0 immediately. After release, no completion write occurs and a fresh mult runs normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: EX-stage multiply/divide unit that owns the HI/LO registers.
// Operations run over a fixed latency while busy is raised. HI/LO are written
// once, at the final cycle of the operation. mthi/mtlo writes are accepted
// only when the unit is idle and no operation is being launched.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDCCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  MDM_WE,
    input  logic [1:0]  MDM_RE,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_out
);

    localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_N + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [1:0]         r_op;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               w_launch;
    logic               w_done;
    logic               w_mtx_ok;
    logic [63:0]        w_mul;
    logic [63:0]        w_div;

    // 64-bit product. Sign-extending both operands first gives the correct
    // signed product in the low 64 bits, so one multiplier serves both ops.
    function automatic logic [63:0] f_mult(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. Signed division truncates toward zero,
    // and the remainder takes the sign of the dividend. The most-negative
    // value divided by -1 is pinned to the result it wraps to. A zero
    // divisor is filtered out by the caller; 0 is returned here only to
    // keep the function total.
    function automatic logic [63:0] f_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        q;
        logic [31:0]        r;
        if (b == 32'h0) begin
            return 64'h0;
        end
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                return {32'h0, 32'h8000_0000};
            end
            sa = $signed(a);
            sb = $signed(b);
            q  = $unsigned(sa / sb);
            r  = $unsigned(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    assign w_launch = (r_state == S_IDLE) && start && !MDCCtrl[2];
    assign w_mtx_ok = (r_state == S_IDLE) && !start;
    assign w_mul    = f_mult(r_a, r_b, !r_op[0]);
    assign w_div    = f_div(r_a, r_b, !r_op[0]);

    // Next-state and countdown: load N on launch, count down while running,
    // and finish on the cycle in which the count reaches 1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = MDCCtrl[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            S_RUN: begin
                if (r_cnt > CNT_W'(1)) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the operands and the operation at launch. These registers are
    // held for the whole run, so changes on A/B have no effect once launched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= '0;
        end else if (w_launch) begin
            r_a  <= A;
            r_b  <= B;
            r_op <= MDCCtrl[1:0];
        end
    end

    // HI/LO: the result is written at completion (a zero divisor leaves them
    // unchanged). mthi/mtlo are accepted only when idle and not launching.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            if (!r_op[1]) begin
                r_hi <= w_mul[63:32];
                r_lo <= w_mul[31:0];
            end else if (r_b != 32'h0) begin
                r_hi <= w_div[63:32];
                r_lo <= w_div[31:0];
            end
        end else if (w_mtx_ok) begin
            if (MDM_WE == 2'b01) begin
                r_hi <= A;
            end else if (MDM_WE == 2'b10) begin
                r_lo <= A;
            end
        end
    end

    // Read port: purely combinational over the current HI/LO.
    always_comb begin
        case (MDM_RE)
            2'b01:   MD_out = r_hi;
            2'b10:   MD_out = r_lo;
            default: MD_out = 32'h0;
        endcase
    end

    assign busy = (r_state == S_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
